// File: rtl/cpu_fetch_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cpu_fetch_align
//  Purpose  : Instruction fetch and alignment stage for the moxie decoder.
//             Fetches 32-bit words from instruction memory and buffers their
//             halfwords in a small circular queue. Presents one complete
//             instruction per cycle to decode: a 2-byte short form or a
//             6-byte long form whose trailing 32 bits form the operand.
//  Ports    : clk_i        - clock, rising edge
//             rst_i        - asynchronous reset, active low
//             stall_i      - decode stall, output register holds
//             flush_i      - redirect to target_i, discard buffered data
//             target_i     - redirect byte address (bit 0 ignored)
//             imem_req_o   - fetch request, held until imem_ack_i
//             imem_adr_o   - word address of the outstanding fetch
//             imem_data_i  - fetched word, big-endian halfword order
//             imem_ack_i   - one-cycle data-valid strobe
//             opcode_o     - first halfword of the presented instruction
//             operand_o    - long-form operand, zero for short form
//             valid_o      - output register holds a real instruction
//             PC_o         - byte address of opcode_o
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000,
    parameter int          QDEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_adr_o,
    input  logic [31:0] imem_data_i,
    input  logic        imem_ack_i,
    output logic [15:0] opcode_o,
    output logic [31:0] operand_o,
    output logic        valid_o,
    output logic [31:0] PC_o
);

    localparam int              c_PW        = $clog2(QDEPTH);
    localparam int              c_CW        = c_PW + 1;
    localparam logic [c_PW-1:0] c_ONE       = c_PW'(1);
    localparam logic [c_PW-1:0] c_TWO       = c_PW'(2);
    localparam logic [c_CW-1:0] c_REQ_LIMIT = c_CW'(QDEPTH - 2);
    localparam logic [c_CW-1:0] c_LONG_MIN  = c_CW'(3);

    // Halfword queue and its bookkeeping
    logic [15:0]     r_q [QDEPTH];
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;

    // Fetch control
    logic [31:0] r_head_pc;
    logic [29:0] r_fetch_wd;    // word index of the next word to request
    logic        r_drop;        // the outstanding request belongs to a stale stream
    logic        r_skip;        // next accepted word starts at its lower halfword
    logic        r_req;
    logic [31:0] r_adr;

    // Output register
    logic        r_valid;
    logic [15:0] r_opcode;
    logic [31:0] r_operand;
    logic [31:0] r_pc;

    logic [15:0]     w_hw0;
    logic [15:0]     w_hw1;
    logic [15:0]     w_hw2;
    logic            w_long;
    logic            w_accept_ack;
    logic [1:0]      w_push_n;
    logic [1:0]      w_pop_n;
    logic [c_CW-1:0] w_count_next;
    logic            w_req_keep;
    logic [29:0]     w_next_wd;
    logic            w_unused_tgt_lsb;

    assign w_hw0 = r_q[r_rd_ptr];
    assign w_hw1 = r_q[r_rd_ptr + c_ONE];
    assign w_hw2 = r_q[r_rd_ptr + c_TWO];

    // Long-form opcodes are recognised from the first (most significant) byte
    always_comb begin
        w_long = 1'b0;
        if (!w_hw0[15]) begin
            case (w_hw0[15:8])
                8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B,
                8'h1D, 8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38,
                8'h39:   w_long = 1'b1;
                default: w_long = 1'b0;
            endcase
        end
    end

    // Ack data is only used when it belongs to the current stream
    assign w_accept_ack = imem_ack_i & r_req & ~r_drop & ~flush_i & rst_i;

    always_comb begin
        w_push_n = 2'd0;
        if (w_accept_ack) begin
            w_push_n = r_skip ? 2'd1 : 2'd2;
        end
    end

    // A long instruction leaves only as a whole, so it waits for all three halfwords
    always_comb begin
        w_pop_n = 2'd0;
        if (!flush_i && !stall_i) begin
            if (!w_long && (r_count != '0)) begin
                w_pop_n = 2'd1;
            end else if (w_long && (r_count >= c_LONG_MIN)) begin
                w_pop_n = 2'd3;
            end
        end
    end

    // A request is only in flight while two free slots are guaranteed, so this never overflows
    assign w_count_next = r_count + c_CW'(w_push_n) - c_CW'(w_pop_n);
    assign w_req_keep   = (w_count_next <= c_REQ_LIMIT);
    assign w_next_wd    = r_fetch_wd + 30'd1;

    assign w_unused_tgt_lsb = target_i[0];

    // Queue storage needs no reset: only entries covered by r_count are ever consumed
    always_ff @(posedge clk_i) begin
        if (w_accept_ack) begin
            if (r_skip) begin
                r_q[r_wr_ptr] <= imem_data_i[15:0];
            end else begin
                r_q[r_wr_ptr]         <= imem_data_i[31:16];
                r_q[r_wr_ptr + c_ONE] <= imem_data_i[15:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_head_pc  <= RESET_PC;
            r_fetch_wd <= RESET_PC[31:2];
            r_drop     <= 1'b0;
            r_skip     <= RESET_PC[1];
            r_req      <= 1'b0;
            r_adr      <= 32'h0;
            r_valid    <= 1'b0;
            r_opcode   <= 16'h0;
            r_operand  <= 32'h0;
            r_pc       <= 32'h0;
        end else if (flush_i) begin
            r_valid    <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_head_pc  <= {target_i[31:1], 1'b0};
            r_skip     <= target_i[1];
            r_fetch_wd <= target_i[31:2];
            if (!r_req || imem_ack_i) begin
                // Nothing left in flight: restart cleanly from the target next cycle
                r_req  <= 1'b0;
                r_drop <= 1'b0;
            end else begin
                // The bus request cannot be withdrawn; mark its data for discard
                r_drop <= 1'b1;
            end
        end else begin
            // Request side
            if (r_req) begin
                if (imem_ack_i) begin
                    if (r_drop) begin
                        r_drop <= 1'b0;
                        r_req  <= 1'b0;
                    end else begin
                        r_fetch_wd <= w_next_wd;
                        r_skip     <= 1'b0;
                        r_req      <= w_req_keep;
                        if (w_req_keep) begin
                            r_adr <= {w_next_wd, 2'b00};
                        end
                    end
                end
            end else if (r_count <= c_REQ_LIMIT) begin
                r_req <= 1'b1;
                r_adr <= {r_fetch_wd, 2'b00};
            end

            // Queue side
            r_wr_ptr <= r_wr_ptr + c_PW'(w_push_n);
            r_rd_ptr <= r_rd_ptr + c_PW'(w_pop_n);
            r_count  <= w_count_next;

            // Output side
            if (!stall_i) begin
                if (w_pop_n != 2'd0) begin
                    r_valid   <= 1'b1;
                    r_opcode  <= w_hw0;
                    r_operand <= w_long ? {w_hw1, w_hw2} : 32'h0;
                    r_pc      <= r_head_pc;
                    r_head_pc <= r_head_pc + (w_long ? 32'd6 : 32'd2);
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign imem_req_o = r_req;
    assign imem_adr_o = r_adr;
    assign valid_o    = r_valid;
    assign opcode_o   = r_opcode;
    assign operand_o  = r_operand;
    assign PC_o       = r_pc;

endmodule
`default_nettype wire
